// File: rtl/role_motion_if.sv
// role_motion_if: control inputs and position/hitbox outputs of the role motion controller.
interface role_motion_if;
  logic tick;
  logic stop;
  logic jump_btn;
  logic duck_btn;
  logic [9:0] point_x;
  logic [9:0] point_y;
  logic [7:0] role_h;
  logic [1:0] state;
  logic airborne;
  modport master (
    output tick, stop, jump_btn, duck_btn,
    input point_x, point_y, role_h, state, airborne
  );
  modport slave (
    input tick, stop, jump_btn, duck_btn,
    output point_x, point_y, role_h, state, airborne
  );
endinterface

// File: rtl/role_motion_ctrl.sv
// role_motion_ctrl: tick-driven gravity jump, multi-jump, duck and landing control of the player role.
// Define ROLE_FAST_FALL_EN to make duck_btn in the air apply double gravity.
module role_motion_ctrl #(
  parameter int X_POS = 10,
  parameter int GROUND_Y = 400,
  parameter int ROLE_H = 43,
  parameter int DUCK_H = 26,
  parameter int JUMP_V0 = 12,
  parameter int GRAVITY = 1,
  parameter int MAX_JUMPS = 2,
  parameter int VEL_W = 8
) (
  input logic clk,
  input logic rst,
  role_motion_if.slave bus
);
  typedef enum logic [1:0] {RUN, AIR, DUCK, LAND} state_t;
  localparam logic [9:0] STAND_Y = 10'(GROUND_Y - ROLE_H);
  localparam logic [9:0] DUCK_Y = 10'(GROUND_Y - DUCK_H);
  localparam logic signed [VEL_W+1:0] STAND_YS = (VEL_W+2)'(GROUND_Y - ROLE_H);
  localparam logic signed [VEL_W-1:0] V0 = VEL_W'(JUMP_V0);
  localparam logic signed [VEL_W:0] VMIN = {2'b11, {(VEL_W-1){1'b0}}};
  localparam logic [1:0] MAXJ = 2'(MAX_JUMPS);
  state_t st;
  logic [9:0] y;
  logic [7:0] h;
  logic signed [VEL_W-1:0] vel;
  logic [1:0] jumps_used;
  logic jump_pend;
  logic jump_btn_d;
  logic signed [VEL_W:0] grav;
  logic signed [VEL_W:0] vel_dec;
  logic signed [VEL_W-1:0] vel_sat;
  logic signed [VEL_W+1:0] y_next;
  logic do_tick;
  logic consume;
`ifdef ROLE_FAST_FALL_EN
  assign grav = (VEL_W+1)'(bus.duck_btn ? 2 * GRAVITY : GRAVITY);
`else
  assign grav = (VEL_W+1)'(GRAVITY);
`endif
  assign vel_dec = (VEL_W+1)'(vel) - grav;
  assign vel_sat = (vel_dec < VMIN) ? VMIN[VEL_W-1:0] : vel_dec[VEL_W-1:0];
  assign y_next = $signed((VEL_W+2)'(y)) - (VEL_W+2)'(vel);
  assign do_tick = bus.tick & ~bus.stop;
  // LAND keeps a pending jump so the following RUN tick launches it
  assign consume = do_tick & (st != LAND);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= RUN;
      y <= STAND_Y;
      h <= 8'(ROLE_H);
      vel <= '0;
      jumps_used <= '0;
      jump_pend <= 1'b0;
      jump_btn_d <= 1'b0;
    end else begin
      jump_btn_d <= bus.jump_btn;
      jump_pend <= ~bus.stop & ((bus.jump_btn & ~jump_btn_d) | (jump_pend & ~consume));
      if (do_tick)
        unique case (st)
          RUN, DUCK:
            if (jump_pend) begin
              st <= AIR;
              y <= STAND_Y;
              h <= 8'(ROLE_H);
              vel <= V0;
              jumps_used <= 2'd1;
            end else if (bus.duck_btn) begin
              st <= DUCK;
              y <= DUCK_Y;
              h <= 8'(DUCK_H);
            end else begin
              st <= RUN;
              y <= STAND_Y;
              h <= 8'(ROLE_H);
            end
          AIR:
            if (jump_pend && jumps_used < MAXJ) begin
              vel <= V0;
              jumps_used <= jumps_used + 2'd1;
            end else if (y_next[VEL_W+1]) begin
              y <= '0;
              vel <= '0;
            end else if (y_next >= STAND_YS) begin
              st <= LAND;
              y <= STAND_Y;
              vel <= '0;
              jumps_used <= '0;
            end else begin
              y <= 10'(y_next);
              vel <= vel_sat;
            end
          LAND: st <= RUN;
        endcase
    end
  assign bus.point_x = 10'(X_POS);
  assign bus.point_y = y;
  assign bus.role_h = h;
  assign bus.state = st;
  assign bus.airborne = (st == AIR);
endmodule

// File: tb/tb_role_motion_ctrl.sv
// tb_role_motion_ctrl: directed vector table, corner sequences and randomized run against a behavioural model.
module tb_role_motion_ctrl;
  localparam int GROUND = 400, RH = 43, DH = 26, V0 = 12, MAXJ = 2;
  localparam int STAND = GROUND - RH, DUCKY = GROUND - DH;
  logic clk = 0;
  logic rst = 0;
  role_motion_if bus ();
  role_motion_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0;
  int m_mode, m_y, m_v, m_j;
  bit m_pend, m_prev;
  typedef struct packed {
    logic jb, db, sp;
    logic [7:0] reps;
    logic [9:0] y;
    logic [7:0] h;
    logic [1:0] st;
  } vec_t;
  vec_t tbl[$];
  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  function automatic void m_reset();
    m_mode = 0; m_y = STAND; m_v = 0; m_j = 0; m_pend = 0; m_prev = 0;
  endfunction
  // behavioural model: mode 0 run, 1 air, 2 duck, 3 land; y is the top edge
  function automatic void m_step(bit t, bit jb, bit db, bit sp);
    bit ev;
    bit used;
    int ny, g;
    ev = jb && !m_prev;
    used = 0;
    g = 1;
`ifdef ROLE_FAST_FALL_EN
    if (db) g = 2;
`endif
    if (t && !sp) begin
      used = (m_mode != 3);
      if (m_mode == 3) m_mode = 0;
      else if (m_mode == 1) begin
        if (m_pend && m_j < MAXJ) begin
          m_v = V0; m_j++;
        end else begin
          ny = m_y - m_v;
          if (ny < 0) begin m_y = 0; m_v = 0; end
          else if (ny >= STAND) begin m_y = STAND; m_v = 0; m_j = 0; m_mode = 3; end
          else begin m_y = ny; m_v = (m_v - g < -128) ? -128 : m_v - g; end
        end
      end else if (m_pend) begin m_mode = 1; m_y = STAND; m_v = V0; m_j = 1; end
      else if (db) begin m_mode = 2; m_y = DUCKY; end
      else begin m_mode = 0; m_y = STAND; end
    end
    m_pend = !sp && (ev || (m_pend && !used));
    m_prev = jb;
  endfunction
  task automatic cyc(input bit t, input bit jb, input bit db, input bit sp);
    bus.tick = t; bus.jump_btn = jb; bus.duck_btn = db; bus.stop = sp;
    @(posedge clk);
    m_step(t, jb, db, sp);
    @(negedge clk);
  endtask
  task automatic tk(input bit jb, input bit db, input bit sp);
    cyc(0, jb, db, sp);
    cyc(1, jb, db, sp);
  endtask
  function automatic void add(bit jb, bit db, bit sp, int reps, int y, int h, int st);
    vec_t v;
    v.jb = jb; v.db = db; v.sp = sp; v.reps = 8'(reps);
    v.y = 10'(y); v.h = 8'(h); v.st = 2'(st);
    tbl.push_back(v);
  endfunction
  task automatic check_out(input string nm, input int y, input int h, input int st);
    check({nm, "_y"}, int'(bus.point_y), y);
    check({nm, "_h"}, int'(bus.role_h), h);
    check({nm, "_state"}, int'(bus.state), st);
    check({nm, "_air"}, int'(bus.airborne), int'(st == 1));
  endtask
  initial begin
    bit jb, db, sp;
    bus.tick = 0; bus.stop = 0; bus.jump_btn = 0; bus.duck_btn = 0;
    add(0,0,0,5, 357,43,0);
    add(1,0,0,1, 357,43,1); add(0,0,0,12, 279,43,1); add(0,0,0,12, 345,43,1);
    add(0,0,0,1, 357,43,3); add(0,0,0,1, 357,43,0);
    add(0,1,0,1, 374,26,2); add(0,1,0,3, 374,26,2); add(0,0,0,1, 357,43,0);
    add(1,1,0,1, 357,43,1); add(0,0,0,24, 345,43,1); add(0,0,0,1, 357,43,3); add(0,0,0,1, 357,43,0);
    add(0,1,0,1, 374,26,2); add(1,1,0,1, 357,43,1); add(0,0,0,24, 345,43,1);
    add(0,0,0,1, 357,43,3); add(0,0,0,1, 357,43,0);
    add(1,0,0,1, 357,43,1); add(0,0,0,5, 307,43,1); add(1,0,0,1, 307,43,1);
    add(0,0,0,12, 229,43,1); add(1,0,0,1, 229,43,1); add(0,0,0,15, 349,43,1);
    add(0,0,0,1, 357,43,3); add(0,0,0,1, 357,43,0);
    add(1,0,0,1, 357,43,1); add(0,0,0,6, 300,43,1);
    add(1,0,1,5, 300,43,1); add(0,0,1,1, 300,43,1); add(1,0,1,4, 300,43,1);
    add(0,0,0,18, 345,43,1); add(0,0,0,1, 357,43,3); add(0,0,0,1, 357,43,0);
    add(1,0,0,1, 357,43,1); add(0,0,0,24, 345,43,1); add(0,0,0,1, 357,43,3);
    add(1,0,0,1, 357,43,0); add(0,0,0,1, 357,43,1); add(0,0,0,24, 345,43,1);
    add(0,0,0,1, 357,43,3); add(0,1,0,1, 357,43,0); add(0,1,0,1, 374,26,2); add(0,0,0,1, 357,43,0);
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("reset_x", int'(bus.point_x), 10);
    check_out("reset", 357, 43, 0);
    foreach (tbl[i]) begin
      for (int r = 0; r < int'(tbl[i].reps); r++) tk(tbl[i].jb, tbl[i].db, tbl[i].sp);
      check_out($sformatf("vec%0d", i), int'(tbl[i].y), int'(tbl[i].h), int'(tbl[i].st));
    end
`ifdef ROLE_FAST_FALL_EN
    tk(1, 0, 0);
    repeat (12) tk(0, 0, 0);
    check_out("ff_apex", 279, 43, 1);
    repeat (9) tk(0, 1, 0);
    check_out("ff_fall", 351, 43, 1);
    tk(0, 1, 0);
    check_out("ff_land", 357, 43, 3);
    tk(0, 0, 0);
`endif
    tk(1, 0, 0);
    repeat (3) tk(0, 0, 0);
    check_out("midjump", 324, 43, 1);
    rst = 0;
    #1;
    check_out("async_rst", 357, 43, 0);
    m_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    tk(0, 0, 0);
    check_out("post_rst", 357, 43, 0);
    jb = 0; db = 0; sp = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) == 0) jb = !jb;
      if ($urandom_range(15) == 0) db = !db;
      sp = sp ? ($urandom_range(7) != 0) : ($urandom_range(39) == 0);
      cyc($urandom_range(2) == 0, jb, db, sp);
      check($sformatf("rand%0d", i),
            int'({bus.point_x, bus.point_y, bus.role_h, bus.state, bus.airborne}),
            int'({10'd10, 10'(m_y), (m_mode == 2) ? 8'(DH) : 8'(RH), 2'(m_mode), m_mode == 1}));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
